sram_bus_arbiter: RTL and testbench

- Shares one sram-like master port between the instruction-fetch requester (IF stage) and the data requester (EX/MEM stage).
- Arbitrates address-phase requests and records the owner of every accepted transaction in an in-order ID FIFO.
- Routes each data_ok and rdata back to the owning requester.
- Sits between the CPU core and the downstream sram-like-to-AXI bridge or SRAM model.

---
 rtl/sram_bus_arbiter_pkg.sv | 25 ++
 rtl/sram_arb_id_fifo.sv | 57 +++++
 rtl/sram_bus_arbiter.sv | 110 +++++++++++
 tb/tb_sram_bus_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bus_arbiter_pkg.sv
// Shared types and constants for the sram-like bus arbiter: owner encoding,
// transfer size codes and the packed address-phase request bundle.
package sram_bus_arbiter_pkg;

  localparam logic ARB_OWNER_INST = 1'b0;
  localparam logic ARB_OWNER_DATA = 1'b1;

  localparam logic [1:0] SRAM_SIZE_B = 2'b00;
  localparam logic [1:0] SRAM_SIZE_H = 2'b01;
  localparam logic [1:0] SRAM_SIZE_W = 2'b10;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sram_req_t;

  // Pointer width for a FIFO of the given depth, never narrower than one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sram_arb_id_fifo.sv
// In-order owner FIFO: one bit per accepted transaction, DEPTH entries deep.
// Push is ignored when full and pop is ignored when empty.
module sram_arb_id_fifo
  import sram_bus_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic full,
  output logic empty
);

  logic             mem [DEPTH];
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] wptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= next_ptr(wptr);
      if (do_pop)  rptr <= next_ptr(rptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Contents need no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one sram-like master port between the inst and data requesters.
// Define SRAM_ARB_RR_EN for round-robin arbitration; default is data-over-inst.
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_en,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic        mem_sram_en,
  output logic        mem_sram_wr,
  output logic [1:0]  mem_sram_size,
  output logic [3:0]  mem_sram_wen,
  output logic [31:0] mem_sram_addr,
  output logic [31:0] mem_sram_wdata,
  input  logic        mem_sram_addr_ok,
  input  logic        mem_sram_data_ok,
  input  logic [31:0] mem_sram_rdata
);

  localparam int ID_PTR_W = ptr_width(OUTSTANDING);

  // Handshake: a request is accepted in the cycle en && addr_ok; each accepted
  // request later sees exactly one data_ok, in acceptance order.
  sram_req_t inst_req;
  sram_req_t data_req;
  sram_req_t mem_req;
  logic      grant_inst;
  logic      grant_data;
  logic      full;
  logic      empty;
  logic      push;
  logic      pop;
  logic      owner_head;

  assign inst_req = {inst_sram_wr, inst_sram_size, inst_sram_wen, inst_sram_addr, inst_sram_wdata};
  assign data_req = {data_sram_wr, data_sram_size, data_sram_wen, data_sram_addr, data_sram_wdata};

`ifdef SRAM_ARB_RR_EN
  logic last_owner;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)   last_owner <= ARB_OWNER_INST;
    else if (push) last_owner <= grant_data;
  end

  // Under contention the side that did not win the last push goes first.
  always_comb begin
    grant_data = data_sram_en && !full && (!inst_sram_en || last_owner == ARB_OWNER_INST);
    grant_inst = inst_sram_en && !full && (!data_sram_en || last_owner == ARB_OWNER_DATA);
  end
`else
  always_comb begin
    grant_data = data_sram_en && !full;
    grant_inst = inst_sram_en && !data_sram_en && !full;
  end
`endif

  assign mem_req = grant_data ? data_req : inst_req;

  assign mem_sram_en    = (grant_data || grant_inst) && resetn;
  assign mem_sram_wr    = mem_req.wr;
  assign mem_sram_size  = mem_req.size;
  assign mem_sram_wen   = mem_req.wen;
  assign mem_sram_addr  = mem_req.addr;
  assign mem_sram_wdata = mem_req.wdata;

  assign push = mem_sram_en && mem_sram_addr_ok;
  assign pop  = mem_sram_data_ok && !empty && resetn;

  assign inst_sram_addr_ok = mem_sram_addr_ok && grant_inst && resetn;
  assign data_sram_addr_ok = mem_sram_addr_ok && grant_data && resetn;
  assign inst_sram_data_ok = pop && (owner_head == ARB_OWNER_INST);
  assign data_sram_data_ok = pop && (owner_head == ARB_OWNER_DATA);
  assign inst_sram_rdata   = mem_sram_rdata;
  assign data_sram_rdata   = mem_sram_rdata;

  sram_arb_id_fifo #(
    .DEPTH (OUTSTANDING),
    .PTR_W (ID_PTR_W)
  ) u_id_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .din    (grant_data ? ARB_OWNER_DATA : ARB_OWNER_INST),
    .dout   (owner_head),
    .full   (full),
    .empty  (empty)
  );

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Self-checking bench for sram_bus_arbiter: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against an owner-queue model.
module tb_sram_bus_arbiter;
  import sram_bus_arbiter_pkg::*;

  localparam int OUT = 2;
  localparam logic [31:0] INST_ADDR = 32'hbfc0_0004;
  localparam logic [31:0] DATA_ADDR = 32'h8000_0010;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic        i_en, i_wr, d_en, d_wr, m_aok, m_dok;
  logic [1:0]  i_size, d_size;
  logic [3:0]  i_wen, d_wen;
  logic [31:0] i_addr, i_wdata, d_addr, d_wdata, m_rdata;
  logic        i_aok, i_dok, d_aok, d_dok, m_en, m_wr;
  logic [1:0]  m_size;
  logic [3:0]  m_wen;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;

  sram_bus_arbiter #(.OUTSTANDING(OUT)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_en(i_en), .inst_sram_wr(i_wr), .inst_sram_size(i_size),
    .inst_sram_wen(i_wen), .inst_sram_addr(i_addr), .inst_sram_wdata(i_wdata),
    .inst_sram_addr_ok(i_aok), .inst_sram_data_ok(i_dok), .inst_sram_rdata(i_rdata),
    .data_sram_en(d_en), .data_sram_wr(d_wr), .data_sram_size(d_size),
    .data_sram_wen(d_wen), .data_sram_addr(d_addr), .data_sram_wdata(d_wdata),
    .data_sram_addr_ok(d_aok), .data_sram_data_ok(d_dok), .data_sram_rdata(d_rdata),
    .mem_sram_en(m_en), .mem_sram_wr(m_wr), .mem_sram_size(m_size),
    .mem_sram_wen(m_wen), .mem_sram_addr(m_addr), .mem_sram_wdata(m_wdata),
    .mem_sram_addr_ok(m_aok), .mem_sram_data_ok(m_dok), .mem_sram_rdata(m_rdata)
  );

  // ---------------- scoreboard / reference model ----------------
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [0:0] exp_q[$];
  logic last_owner_m = ARB_OWNER_INST;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [4:0] dut_hs();
    return {m_en, i_aok, d_aok, i_dok, d_dok};
  endfunction

  function automatic logic [70:0] dut_fields();
    return {m_wr, m_size, m_wen, m_addr, m_wdata};
  endfunction

  task automatic model_grant(output logic gd, output logic gi);
    logic full_m;
    full_m = (exp_q.size() == OUT);
    gd = 1'b0;
    gi = 1'b0;
    if (!full_m) begin
      if (i_en && d_en) begin
`ifdef SRAM_ARB_RR_EN
        gd = (last_owner_m == ARB_OWNER_INST);
        gi = !gd;
`else
        gd = 1'b1;
`endif
      end else begin
        gd = d_en;
        gi = i_en;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic gd, gi, popm, own;
    model_grant(gd, gi);
    popm = m_dok && (exp_q.size() != 0);
    own  = popm ? exp_q[0] : 1'b0;
    chk({tag, " hs"}, 128'(dut_hs()),
        128'({gd | gi, m_aok & gi, m_aok & gd, popm & ~own, popm & own}));
    chk({tag, " fields"}, 128'(dut_fields()),
        gd ? 128'({d_wr, d_size, d_wen, d_addr, d_wdata})
           : 128'({i_wr, i_size, i_wen, i_addr, i_wdata}));
    chk({tag, " rdata"}, 128'({i_rdata, d_rdata}), 128'({m_rdata, m_rdata}));
  endtask

  // Applies the cycle's transfers to the model: pop sees pre-edge occupancy.
  task automatic tick();
    logic gd, gi;
    @(posedge clk);
    model_grant(gd, gi);
    if (m_dok && exp_q.size() != 0) void'(exp_q.pop_front());
    if ((gd || gi) && m_aok) begin
      exp_q.push_back(gd);
      last_owner_m = gd;
    end
    #1;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic ien, input logic den, input logic aok, input logic dok);
    i_en = ien; d_en = den; m_aok = aok; m_dok = dok;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic ien, den, aok, dok;
    logic men, iaok, daok, idok, ddok;
    logic sel_data;
  } vec_t;

  vec_t vecs[15];

  initial begin
    //          ien den aok dok _ men iaok daok idok ddok _ sel
    vecs[0]  = 10'b0110_10100_1; // data store accepted
    vecs[1]  = 10'b1010_11000_0; // inst read accepted, now full
    vecs[2]  = 10'b1010_00000_0; // full stall
    vecs[3]  = 10'b1011_00001_0; // pop data, still stalled this cycle
    vecs[4]  = 10'b1010_11000_0; // slot freed, inst accepted
    vecs[5]  = 10'b0001_00010_0;
    vecs[6]  = 10'b0001_00010_0;
    vecs[7]  = 10'b0001_00000_0; // spurious data_ok
    vecs[8]  = 10'b1110_10100_1; // contention after an inst push
`ifdef SRAM_ARB_RR_EN
    vecs[9]  = 10'b1110_11000_0; // last owner data: inst wins
    vecs[11] = 10'b0001_00010_0;
`else
    vecs[9]  = 10'b1110_10100_1; // fixed priority: data wins again
    vecs[11] = 10'b0001_00001_0;
`endif
    vecs[10] = 10'b1111_00001_0; // full, pop first data
    vecs[12] = 10'b1100_10000_1; // no addr_ok: nothing accepted
    vecs[13] = 10'b1111_10100_1; // spurious pop ignored, push accepted
    vecs[14] = 10'b0001_00001_0;

    resetn = 1'b0;
    i_wr = 1'b0; i_size = SRAM_SIZE_W; i_wen = 4'h0; i_addr = INST_ADDR; i_wdata = 32'h0;
    d_wr = 1'b1; d_size = SRAM_SIZE_W; d_wen = 4'hf; d_addr = DATA_ADDR; d_wdata = 32'h1234_5678;
    m_rdata = 32'h0;
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    #2;
    chk("reset hs", 128'(dut_hs()), 128'(5'b00000));
    @(posedge clk); #1;
    resetn = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #4;
    chk("idle after reset", 128'(dut_hs()), 128'(5'b00000));
    tick();

    for (int r = 0; r < 15; r++) begin
      drive(vecs[r].ien, vecs[r].den, vecs[r].aok, vecs[r].dok);
      m_rdata = 32'h1000_0000 + 32'(r);
      #4;
      chk($sformatf("row%0d hs", r), 128'(dut_hs()),
          128'({vecs[r].men, vecs[r].iaok, vecs[r].daok, vecs[r].idok, vecs[r].ddok}));
      chk($sformatf("row%0d addr", r), 128'(m_addr),
          128'(vecs[r].sel_data ? DATA_ADDR : INST_ADDR));
      chk($sformatf("row%0d rdata", r), 128'({i_rdata, d_rdata}), 128'({m_rdata, m_rdata}));
      tick();
    end

    // Lone inst read: addr_ok one cycle late, data_ok two cycles after that.
    i_addr = 32'hbfc0_0000;
    drive(1'b1, 1'b0, 1'b0, 1'b0); #4;
    chk("lone c0 hs", 128'(dut_hs()), 128'(5'b10000));
    chk("lone c0 addr", 128'(m_addr), 128'(32'hbfc0_0000));
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0); #4;
    chk("lone c1 hs", 128'(dut_hs()), 128'(5'b11000));
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0); #4;
    chk("lone c2 hs", 128'(dut_hs()), 128'(5'b00000));
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1); m_rdata = 32'h3c1d_0000; #4;
    chk("lone c3 hs", 128'(dut_hs()), 128'(5'b00010));
    chk("lone c3 rdata", 128'(i_rdata), 128'(32'h3c1d_0000));
    tick();

    // Reset mid-flight with one transaction outstanding.
    drive(1'b1, 1'b0, 1'b1, 1'b0); #4;
    check_model("rst pre");
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    chk("rst async hs", 128'(dut_hs()), 128'(5'b00000));
    exp_q.delete();
    last_owner_m = ARB_OWNER_INST;
    @(posedge clk); #1;
    resetn = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b1); #4;
    chk("rst late data_ok", 128'(dut_hs()), 128'(5'b00000));
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0); #4;
      check_model($sformatf("rst refill%0d", k));
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1); #4; check_model("rst drain0"); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1); #4; check_model("rst drain1"); tick();

    // Randomized traffic; requesters hold their fields until accepted.
    begin
      logic i_pend, d_pend, gd, gi;
      i_pend = 1'b0;
      d_pend = 1'b0;
      for (int c = 0; c < 500; c++) begin
        if (!i_pend) begin
          i_en = ($urandom_range(0, 2) != 0);
          i_wr = 1'($urandom_range(0, 1));
          i_size = 2'($urandom_range(0, 2));
          i_wen = 4'($urandom);
          i_addr = $urandom;
          i_wdata = $urandom;
          i_pend = i_en;
        end
        if (!d_pend) begin
          d_en = ($urandom_range(0, 2) != 0);
          d_wr = 1'($urandom_range(0, 1));
          d_size = 2'($urandom_range(0, 2));
          d_wen = 4'($urandom);
          d_addr = $urandom;
          d_wdata = $urandom;
          d_pend = d_en;
        end
        m_aok = ($urandom_range(0, 3) != 0);
        m_dok = ($urandom_range(0, 2) == 0);
        m_rdata = $urandom;
        #4;
        check_model($sformatf("rand%0d", c));
        model_grant(gd, gi);
        if (gi && m_aok) i_pend = 1'b0;
        if (gd && m_aok) d_pend = 1'b0;
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
